// File: rtl/sockit_i2c_slave.sv
// ---------------------------------------------------------------------------
// sockit_i2c_slave
//
// I2C slave for the shared open-drain SCL/SDA bus. The pads are sampled in the
// clk domain through a 2-flop synchronizer and a FLT-sample glitch filter.
// START, repeated START and STOP are recognised in every state. Write bytes
// are delivered on rx_vld/rx_dat; read bytes are fetched via tx_req/tx_dat.
// The bus is driven only through pull-low enables (1 = drive 0).
//
// Optional feature macro: SOCKIT_I2C_SLAVE_STRETCH_EN
//   defined   : tx_vld port exists; tx_req is held until tx_vld and SCL is
//               stretched (scl_e=1) while the read byte is outstanding.
//   undefined : no tx_vld port; scl_e tied to 0; tx_req is a 1-cycle pulse
//               and tx_dat is loaded in that same cycle.
//
// Ports:
//   clk, rst_n     system clock (>= 16x SCL), async active-low reset
//   scl_i, sda_i   pad inputs
//   scl_e, sda_e   pull-low enables for SCL (stretching) and SDA
//   busy           high from START to STOP, whatever the address
//   rx_vld, rx_dat received write byte strobe and data
//   tx_req, tx_dat read byte request and data
//   tx_vld         read byte valid (stretch build only)
// ---------------------------------------------------------------------------
module sockit_i2c_slave #(
  parameter logic [6:0] ADR = 7'h2a,
  parameter int         FLT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_e,
  output logic       sda_e,
  output logic       busy,
  output logic       rx_vld,
  output logic [7:0] rx_dat,
  output logic       tx_req,
  input  logic [7:0] tx_dat
`ifdef SOCKIT_I2C_SLAVE_STRETCH_EN
  ,
  input  logic       tx_vld
`endif
);

  typedef enum logic [2:0] {IDLE, ADDR, AACK, WDAT, WACK, RDAT, RACK} state_t;

  // Line index 0 = SCL, 1 = SDA.
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      flt_q, flt_d;
  logic [1:0]      dly_q;
  logic [1:0][3:0] cnt_q, cnt_d;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] sh_q, sh_d;
  logic       rw_q, rw_d;
  logic       ph_q, ph_d;      // ACK-phase flag: driving ACK / master ACKed
  logic       sda_e_q, sda_e_d;
  logic       busy_q, busy_d;
  logic       rx_vld_q, rx_vld_d;
  logic [7:0] rx_dat_q, rx_dat_d;
  logic       fire;            // falling edge that starts a read byte

`ifdef SOCKIT_I2C_SLAVE_STRETCH_EN
  logic wait_q, wait_d;        // read byte outstanding, SCL stretched
  logic tx_req_q, tx_req_d;
  logic scl_e_q, scl_e_d;
  logic load;
`endif

  // Glitch filter: a new level is accepted after FLT consecutive samples
  // that differ from the current filtered level.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      flt_d[i] = flt_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != flt_q[i]) begin
        if (cnt_q[i] == 4'(FLT - 1)) flt_d[i] = sync2_q[i];
        else                         cnt_d[i] = cnt_q[i] + 4'd1;
      end
    end
  end

  // Bus lines idle high, so the whole input path resets to 1.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      flt_q   <= 2'b11;
      dly_q   <= 2'b11;
      cnt_q   <= '0;
    end else begin
      sync1_q <= {sda_i, scl_i};
      sync2_q <= sync1_q;
      flt_q   <= flt_d;
      dly_q   <= flt_q;
      cnt_q   <= cnt_d;
    end
  end

  logic scl_f, sda_f, scl_rise, scl_fall, start, stop;
  assign scl_f    = flt_q[0];
  assign sda_f    = flt_q[1];
  assign scl_rise =  scl_f & ~dly_q[0];
  assign scl_fall = ~scl_f &  dly_q[0];
  assign start    =  scl_f & dly_q[0] &  dly_q[1] & ~sda_f;
  assign stop     =  scl_f & dly_q[0] & ~dly_q[1] &  sda_f;

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    rw_d      = rw_q;
    ph_d      = ph_q;
    sda_e_d   = sda_e_q;
    busy_d    = busy_q;
    rx_vld_d  = 1'b0;
    rx_dat_d  = rx_dat_q;
    fire      = 1'b0;
`ifdef SOCKIT_I2C_SLAVE_STRETCH_EN
    wait_d    = wait_q;
    load      = 1'b0;
`endif

    // Bus conditions win over any bit-level action in the same cycle.
    if (start) begin
      state_d   = ADDR;
      busy_d    = 1'b1;
      sda_e_d   = 1'b0;
      bit_cnt_d = '0;
      ph_d      = 1'b0;
`ifdef SOCKIT_I2C_SLAVE_STRETCH_EN
      wait_d    = 1'b0;
`endif
    end else if (stop) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      sda_e_d = 1'b0;
      ph_d    = 1'b0;
`ifdef SOCKIT_I2C_SLAVE_STRETCH_EN
      wait_d  = 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: ;
        ADDR: if (scl_rise) begin
          sh_d      = {sh_q[6:0], sda_f};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            // Mismatch: stay silent until the next START/STOP; busy stays set.
            if (sh_q[6:0] == ADR) begin
              state_d = AACK;
              rw_d    = sda_f;
              ph_d    = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end
        end
        AACK, WACK: if (scl_fall) begin
          if (!ph_q) begin
            sda_e_d = 1'b1;
            ph_d    = 1'b1;
          end else begin
            sda_e_d   = 1'b0;
            ph_d      = 1'b0;
            bit_cnt_d = '0;
            if (state_q == AACK && rw_q) fire = 1'b1;
            else                         state_d = WDAT;
          end
        end
        WDAT: if (scl_rise) begin
          sh_d      = {sh_q[6:0], sda_f};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_dat_d = {sh_q[6:0], sda_f};
            rx_vld_d = 1'b1;
            state_d  = WACK;
            ph_d     = 1'b0;
          end
        end
        RDAT: begin
`ifdef SOCKIT_I2C_SLAVE_STRETCH_EN
          if (wait_q) begin
            if (tx_vld) begin
              load    = 1'b1;
              wait_d  = 1'b0;
              sh_d    = tx_dat;
              sda_e_d = ~tx_dat[7];
            end
          end else
`endif
          if (scl_fall) begin
            if (bit_cnt_q == 3'd7) begin
              sda_e_d   = 1'b0;
              state_d   = RACK;
              ph_d      = 1'b0;
              bit_cnt_d = '0;
            end else begin
              sh_d      = {sh_q[6:0], 1'b0};
              sda_e_d   = ~sh_q[6];
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
        RACK: begin
          if (scl_rise) begin
            if (!sda_f) ph_d    = 1'b1;
            else        state_d = IDLE;
          end else if (scl_fall && ph_q) begin
            ph_d = 1'b0;
            fire = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase

      if (fire) begin
        state_d   = RDAT;
        bit_cnt_d = '0;
`ifdef SOCKIT_I2C_SLAVE_STRETCH_EN
        wait_d    = 1'b1;
        sda_e_d   = 1'b0;
`else
        sh_d      = tx_dat;
        sda_e_d   = ~tx_dat[7];
`endif
      end
    end

`ifdef SOCKIT_I2C_SLAVE_STRETCH_EN
    tx_req_d = wait_d;
    // Holding through the load cycle puts the first bit on SDA before SCL
    // is released.
    scl_e_d  = wait_d | load;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      rw_q      <= 1'b0;
      ph_q      <= 1'b0;
      sda_e_q   <= 1'b0;
      busy_q    <= 1'b0;
      rx_vld_q  <= 1'b0;
      rx_dat_q  <= '0;
`ifdef SOCKIT_I2C_SLAVE_STRETCH_EN
      wait_q    <= 1'b0;
      tx_req_q  <= 1'b0;
      scl_e_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      rw_q      <= rw_d;
      ph_q      <= ph_d;
      sda_e_q   <= sda_e_d;
      busy_q    <= busy_d;
      rx_vld_q  <= rx_vld_d;
      rx_dat_q  <= rx_dat_d;
`ifdef SOCKIT_I2C_SLAVE_STRETCH_EN
      wait_q    <= wait_d;
      tx_req_q  <= tx_req_d;
      scl_e_q   <= scl_e_d;
`endif
    end
  end

  assign sda_e  = sda_e_q;
  assign busy   = busy_q;
  assign rx_vld = rx_vld_q;
  assign rx_dat = rx_dat_q;
`ifdef SOCKIT_I2C_SLAVE_STRETCH_EN
  assign tx_req = tx_req_q;
  assign scl_e  = scl_e_q;
`else
  // Same-cycle request and load; fire is decoded from registered state.
  assign tx_req = fire;
  assign scl_e  = 1'b0;
`endif

endmodule

// File: tb/tb_sockit_i2c_slave.sv
// ---------------------------------------------------------------------------
// Testbench for sockit_i2c_slave: a behavioural I2C master drives the
// open-drain bus and checks ACKs, received bytes, read data and strobes.
// ---------------------------------------------------------------------------
module tb_sockit_i2c_slave;

  localparam int Q = 20;   // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_scl = 1'b1;  // master side: 1 = release, 0 = pull low
  logic       m_sda = 1'b1;
  logic       scl, sda;
  logic       scl_e, sda_e, busy, rx_vld, tx_req;
  logic [7:0] rx_dat, tx_dat;
  logic       tx_vld = 1'b0;

  logic [7:0] tx_mem [16];
  logic [3:0] tx_idx = '0;

  int vec = 0;
  int err = 0;

  // Monitor counters (written only by the monitor process).
  int   rx_cnt = 0, req_cnt = 0, sda_e_cnt = 0, scl_e_cnt = 0, busy_gap = 0;
  int   dcnt = 0;
  int   stretch_dly = 2;
  logic req_prev = 1'b0;
  logic in_xfer = 1'b0;

  always #5 clk = ~clk;

  assign scl    = m_scl & ~scl_e;
  assign sda    = m_sda & ~sda_e;
  assign tx_dat = tx_mem[tx_idx];

  sockit_i2c_slave dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .scl_i  (scl),
    .sda_i  (sda),
    .scl_e  (scl_e),
    .sda_e  (sda_e),
    .busy   (busy),
    .rx_vld (rx_vld),
    .rx_dat (rx_dat),
    .tx_req (tx_req),
    .tx_dat (tx_dat)
`ifdef SOCKIT_I2C_SLAVE_STRETCH_EN
    ,
    .tx_vld (tx_vld)
`endif
  );

  always @(negedge clk) begin
    req_prev <= tx_req;
    if (tx_req && !req_prev) req_cnt <= req_cnt + 1;
    if (req_prev && !tx_req) tx_idx <= tx_idx + 4'd1;
    if (rx_vld) rx_cnt <= rx_cnt + 1;
    if (sda_e) sda_e_cnt <= sda_e_cnt + 1;
    if (scl_e) scl_e_cnt <= scl_e_cnt + 1;
    if (in_xfer && !busy) busy_gap <= busy_gap + 1;
    if (tx_req && !tx_vld) begin
      if (dcnt >= stretch_dly) begin
        tx_vld <= 1'b1;
        dcnt   <= 0;
      end else begin
        dcnt <= dcnt + 1;
      end
    end else begin
      tx_vld <= 1'b0;
      dcnt   <= 0;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_release();
    m_scl = 1'b1;
    for (int i = 0; i < 4000 && scl !== 1'b1; i++) @(negedge clk);
    if (scl !== 1'b1) begin
      vec++; err++;
      $display("FAIL scl_release: SCL=%b after 4000 cycles, want 1", scl);
    end
  endtask

  task automatic put_bit(input logic b, output logic s);
    m_sda = b;
    wait_clk(Q);
    scl_release();
    wait_clk(Q);
    s = sda;
    wait_clk(Q);
    m_scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    wait_clk(Q);
    scl_release();
    wait_clk(Q);
    m_sda = 1'b0;
    wait_clk(Q);
    m_scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    wait_clk(Q);
    scl_release();
    wait_clk(Q);
    m_sda = 1'b1;
    wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) put_bit(d[i], s);
    put_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d, output logic s_ack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      put_bit(1'b1, s);
      d[i] = s;
    end
    put_bit(mack, s_ack);
  endtask

  task automatic test_reset();
    wait_clk(3);
    vec++;
    if ({scl_e, sda_e, busy, rx_vld, tx_req} !== 5'b0) begin
      err++;
      $display("FAIL reset_ctrl: got %b, want 00000", {scl_e, sda_e, busy, rx_vld, tx_req});
    end
    vec++;
    if (rx_dat !== 8'h00) begin
      err++;
      $display("FAIL reset_rx_dat: got %h, want 00", rx_dat);
    end
    rst_n = 1'b1;
    wait_clk(Q);
  endtask

  task automatic test_write();
    int rx0, gap0, req0;
    logic ack;
    rx0 = rx_cnt; gap0 = busy_gap; req0 = req_cnt;
    i2c_start();
    in_xfer = 1'b1;
    write_byte(8'h54, ack);
    vec++; if (ack !== 1'b0) begin err++; $display("FAIL wr_addr_ack: got %b, want 0", ack); end
    write_byte(8'hA5, ack);
    vec++; if (ack !== 1'b0) begin err++; $display("FAIL wr_data_ack: got %b, want 0", ack); end
    in_xfer = 1'b0;
    i2c_stop();
    wait_clk(Q);
    vec++; if (rx_cnt - rx0 !== 1) begin err++; $display("FAIL wr_rx_vld_cycles: got %0d, want 1", rx_cnt - rx0); end
    vec++; if (rx_dat !== 8'hA5) begin err++; $display("FAIL wr_rx_dat: got %h, want a5", rx_dat); end
    vec++; if (busy_gap - gap0 !== 0) begin err++; $display("FAIL wr_busy_gap: got %0d, want 0", busy_gap - gap0); end
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL wr_busy_after_stop: got %b, want 0", busy); end
    vec++; if (req_cnt - req0 !== 0) begin err++; $display("FAIL wr_tx_req: got %0d, want 0", req_cnt - req0); end
  endtask

  task automatic test_read();
    int req0;
    logic ack, s;
    logic [7:0] d;
    req0 = req_cnt;
    tx_mem[tx_idx] = 8'h3C;
    i2c_start();
    write_byte(8'h55, ack);
    vec++; if (ack !== 1'b0) begin err++; $display("FAIL rd_addr_ack: got %b, want 0", ack); end
    read_byte(1'b1, d, s);
    vec++; if (d !== 8'h3C) begin err++; $display("FAIL rd_data: got %h, want 3c", d); end
    vec++; if (s !== 1'b1) begin err++; $display("FAIL rd_sda_released: got %b, want 1", s); end
    i2c_stop();
    wait_clk(Q);
    vec++; if (req_cnt - req0 !== 1) begin err++; $display("FAIL rd_tx_req: got %0d, want 1", req_cnt - req0); end
    vec++; if (sda_e !== 1'b0) begin err++; $display("FAIL rd_sda_e_idle: got %b, want 0", sda_e); end
  endtask

  task automatic test_mismatch();
    int rx0, req0, se0, gap0;
    logic ack;
    rx0 = rx_cnt; req0 = req_cnt; se0 = sda_e_cnt; gap0 = busy_gap;
    i2c_start();
    in_xfer = 1'b1;
    write_byte(8'h56, ack);
    vec++; if (ack !== 1'b1) begin err++; $display("FAIL mm_addr_nack: got %b, want 1", ack); end
    write_byte(8'h11, ack);
    vec++; if (ack !== 1'b1) begin err++; $display("FAIL mm_data_nack: got %b, want 1", ack); end
    in_xfer = 1'b0;
    i2c_stop();
    wait_clk(Q);
    vec++; if (sda_e_cnt - se0 !== 0) begin err++; $display("FAIL mm_sda_e: got %0d cycles, want 0", sda_e_cnt - se0); end
    vec++; if (rx_cnt - rx0 !== 0) begin err++; $display("FAIL mm_rx_vld: got %0d, want 0", rx_cnt - rx0); end
    vec++; if (req_cnt - req0 !== 0) begin err++; $display("FAIL mm_tx_req: got %0d, want 0", req_cnt - req0); end
    vec++; if (busy_gap - gap0 !== 0) begin err++; $display("FAIL mm_busy_gap: got %0d, want 0", busy_gap - gap0); end
  endtask

  task automatic test_repeated_start();
    int rx0, req0;
    logic ack, s;
    logic [7:0] d;
    rx0 = rx_cnt; req0 = req_cnt;
    tx_mem[tx_idx]        = 8'h7E;
    tx_mem[tx_idx + 4'd1] = 8'h81;
    i2c_start();
    write_byte(8'h54, ack);
    vec++; if (ack !== 1'b0) begin err++; $display("FAIL rs_wr_addr_ack: got %b, want 0", ack); end
    write_byte(8'h01, ack);
    vec++; if (ack !== 1'b0) begin err++; $display("FAIL rs_wr_data_ack: got %b, want 0", ack); end
    i2c_start();
    write_byte(8'h55, ack);
    vec++; if (ack !== 1'b0) begin err++; $display("FAIL rs_rd_addr_ack: got %b, want 0", ack); end
    read_byte(1'b0, d, s);
    vec++; if (d !== 8'h7E) begin err++; $display("FAIL rs_rd_byte0: got %h, want 7e", d); end
    read_byte(1'b1, d, s);
    vec++; if (d !== 8'h81) begin err++; $display("FAIL rs_rd_byte1: got %h, want 81", d); end
    vec++; if (s !== 1'b1) begin err++; $display("FAIL rs_sda_released: got %b, want 1", s); end
    i2c_stop();
    wait_clk(Q);
    vec++; if (rx_dat !== 8'h01) begin err++; $display("FAIL rs_rx_dat: got %h, want 01", rx_dat); end
    vec++; if (rx_cnt - rx0 !== 1) begin err++; $display("FAIL rs_rx_vld: got %0d, want 1", rx_cnt - rx0); end
    vec++; if (req_cnt - req0 !== 2) begin err++; $display("FAIL rs_tx_req: got %0d, want 2", req_cnt - req0); end
  endtask

  task automatic test_reset_mid_byte();
    logic ack, s;
    i2c_start();
    write_byte(8'h54, ack);
    for (int i = 0; i < 3; i++) put_bit(1'b1, s);
    m_sda = 1'b0;
    wait_clk(Q);
    scl_release();
    wait_clk(Q);
    rst_n = 1'b0;
    #1;
    vec++;
    if ({scl_e, sda_e, busy, rx_vld, tx_req} !== 5'b0) begin
      err++;
      $display("FAIL mid_reset_ctrl: got %b, want 00000", {scl_e, sda_e, busy, rx_vld, tx_req});
    end
    vec++; if (rx_dat !== 8'h00) begin err++; $display("FAIL mid_reset_rx_dat: got %h, want 00", rx_dat); end
    m_sda = 1'b1;
    m_scl = 1'b1;
    wait_clk(Q);
    rst_n = 1'b1;
    wait_clk(Q);
    i2c_start();
    write_byte(8'h54, ack);
    vec++; if (ack !== 1'b0) begin err++; $display("FAIL mid_reset_addr_ack: got %b, want 0", ack); end
    vec++; if (busy !== 1'b1) begin err++; $display("FAIL mid_reset_busy: got %b, want 1", busy); end
    i2c_stop();
    wait_clk(Q);
  endtask

`ifdef SOCKIT_I2C_SLAVE_STRETCH_EN
  task automatic test_stretch();
    int se0;
    logic ack, s;
    logic [7:0] d;
    se0 = scl_e_cnt;
    stretch_dly = 200;
    tx_mem[tx_idx] = 8'hC3;
    i2c_start();
    write_byte(8'h55, ack);
    vec++; if (ack !== 1'b0) begin err++; $display("FAIL st_addr_ack: got %b, want 0", ack); end
    read_byte(1'b1, d, s);
    vec++; if (d !== 8'hC3) begin err++; $display("FAIL st_data: got %h, want c3", d); end
    i2c_stop();
    wait_clk(Q);
    vec++;
    if (scl_e_cnt - se0 < 200 || scl_e_cnt - se0 > 215) begin
      err++;
      $display("FAIL st_scl_hold: got %0d cycles, want 200..215", scl_e_cnt - se0);
    end
    stretch_dly = 2;
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) tx_mem[i] = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_mismatch();
    test_repeated_start();
    test_reset_mid_byte();
`ifdef SOCKIT_I2C_SLAVE_STRETCH_EN
    test_stretch();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
